// File: rtl/axis_dsrc_pkg.sv
// Shared definitions for the AXI-Stream data source: command codes, FSM states and
// the checksum step that the matching sink also uses.
package axis_dsrc_pkg;

   localparam logic [31:0] CMD_START = 32'd1;
   localparam logic [31:0] CMD_RESET = 32'd2;
   localparam logic [31:0] CMD_STOP  = 32'd3;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // Rotate right by one, then add; must stay bit-identical with the sink side.
   function automatic logic [63:0] cksum_step(input logic [63:0] sum, input logic [63:0] data);
      return {sum[0], sum[63:1]} + data;
   endfunction

endpackage

// File: rtl/axis_dsrc_ctrl.sv
// Control FSM for the data source: command decode, beat/packet counters and TVALID/TLAST.
module axis_dsrc_ctrl #(
   parameter int NB        = 4,
   parameter int PKT_WORDS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] cmd,
   input  logic        new_cmd,
   input  logic [31:0] xfer_bytes,
   input  logic        tready,
   output logic        tvalid,
   output logic        tlast,
   output logic        hs,
   output logic        start,
   output logic        clear,
   output logic [31:0] beat_idx,
   output logic [2:0]  stat_bits
);
   import axis_dsrc_pkg::*;

   localparam int PW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
   localparam logic [PW-1:0] PKT_LAST = PW'(PKT_WORDS - 1);

   state_t        state_reg;
   logic [31:0]   beat_idx_reg;
   logic [PW-1:0] pkt_cnt_reg;
   logic [31:0]   target_reg;
   logic          finite_reg;
   logic          stop_pend_reg;
   logic          tx_done_reg;

   logic [32:0]   round_up;
   logic [31:0]   target_calc;
   logic          stop_req;
   logic          final_beat;
   logic          pkt_end;

   // Beat target is ceil(xfer_bytes / NB); 33 bits so the round-up cannot overflow.
   assign round_up    = {1'b0, xfer_bytes} + 33'(NB - 1);
   assign target_calc = 32'(round_up / 33'(NB));

   assign start    = new_cmd && (cmd == CMD_START) && (state_reg != ST_RUN);
   assign clear    = new_cmd && (cmd == CMD_RESET) && (state_reg != ST_RUN);
   assign stop_req = new_cmd && (cmd == CMD_STOP)  && (state_reg == ST_RUN);

   assign tvalid     = (state_reg == ST_RUN);
   assign hs         = tvalid && tready;
   assign final_beat = finite_reg && (beat_idx_reg == target_reg - 32'd1);
   assign pkt_end    = (pkt_cnt_reg == PKT_LAST);
   assign tlast      = tvalid && (pkt_end || final_beat);

   assign beat_idx  = beat_idx_reg;
   assign stat_bits = {stop_pend_reg, tx_done_reg, tvalid};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         beat_idx_reg  <= 32'd0;
         pkt_cnt_reg   <= '0;
         target_reg    <= 32'd0;
         finite_reg    <= 1'b0;
         stop_pend_reg <= 1'b0;
         tx_done_reg   <= 1'b0;
      end else if (start) begin
         state_reg     <= ST_RUN;
         beat_idx_reg  <= 32'd0;
         pkt_cnt_reg   <= '0;
         target_reg    <= target_calc;
         finite_reg    <= (xfer_bytes != 32'd0);
         stop_pend_reg <= 1'b0;
         tx_done_reg   <= 1'b0;
      end else if (clear) begin
         state_reg   <= ST_IDLE;
         tx_done_reg <= 1'b0;
      end else if (state_reg == ST_RUN) begin
         if (hs) begin
            beat_idx_reg <= beat_idx_reg + 32'd1;
            pkt_cnt_reg  <= tlast ? '0 : pkt_cnt_reg + PW'(1);
            // A finished transfer wins over a stop arriving on its last beat.
            if (final_beat) begin
               state_reg     <= ST_DONE;
               tx_done_reg   <= 1'b1;
               stop_pend_reg <= 1'b0;
            end else if (stop_pend_reg || stop_req) begin
               state_reg     <= ST_IDLE;
               stop_pend_reg <= 1'b0;
            end
         end else if (stop_req) begin
            stop_pend_reg <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_dsrc.sv
// AXI-Stream counting-pattern source with byte counter and rotate-add checksum,
// controlled through the same cmd/new_cmd/stat scheme as the sink.
module axis_dsrc #(
   parameter int C_M_AXIS_TDATA_NUM_BYTES = 4,
   parameter int C_PKT_WORDS              = 16
) (
   input  logic                                    AXIS_ACLK,
   input  logic                                    AXIS_ARESET,
   output logic                                    M_AXIS_TVALID,
   input  logic                                    M_AXIS_TREADY,
   output logic [8*C_M_AXIS_TDATA_NUM_BYTES-1:0]   M_AXIS_TDATA,
   output logic [C_M_AXIS_TDATA_NUM_BYTES-1:0]     M_AXIS_TSTRB,
   output logic                                    M_AXIS_TLAST,
   input  logic [31:0]                             cmd,
   input  logic                                    new_cmd,
   input  logic [31:0]                             xfer_bytes,
   input  logic [31:0]                             seed,
   output logic [31:0]                             stat,
   output logic [31:0]                             sent_bytes,
   output logic [63:0]                             checksum
);
   import axis_dsrc_pkg::*;

   localparam int NB = C_M_AXIS_TDATA_NUM_BYTES;

   logic        tvalid;
   logic        tlast;
   logic        hs;
   logic        start;
   logic        clear;
   logic [31:0] beat_idx;
   logic [2:0]  stat_bits;

   logic [31:0] seed_reg;
   logic [31:0] sent_reg;
   logic [63:0] cksum_reg;
   logic [31:0] pattern;

   axis_dsrc_ctrl #(
      .NB        (NB),
      .PKT_WORDS (C_PKT_WORDS)
   ) u_ctrl (
      .clk        (AXIS_ACLK),
      .rst        (AXIS_ARESET),
      .cmd        (cmd),
      .new_cmd    (new_cmd),
      .xfer_bytes (xfer_bytes),
      .tready     (M_AXIS_TREADY),
      .tvalid     (tvalid),
      .tlast      (tlast),
      .hs         (hs),
      .start      (start),
      .clear      (clear),
      .beat_idx   (beat_idx),
      .stat_bits  (stat_bits)
   );

   assign pattern = seed_reg + beat_idx;

   // The 32-bit pattern is zero-extended (or truncated) to the bus; outputs idle at zero.
   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_lane
         if (gi < 4) begin : g_pat
            assign M_AXIS_TDATA[8*gi +: 8] = tvalid ? pattern[8*gi +: 8] : 8'h00;
         end else begin : g_zero
            assign M_AXIS_TDATA[8*gi +: 8] = 8'h00;
         end
         assign M_AXIS_TSTRB[gi] = tvalid;
      end
   endgenerate

   assign M_AXIS_TVALID = tvalid;
   assign M_AXIS_TLAST  = tlast;
   assign stat          = {29'h0, stat_bits};
   assign sent_bytes    = sent_reg;
   assign checksum      = cksum_reg;

   always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
      if (AXIS_ARESET) begin
         seed_reg  <= 32'd0;
         sent_reg  <= 32'd0;
         cksum_reg <= 64'd0;
      end else begin
         if (start) begin
            seed_reg <= seed;
         end
         // Clear is only honoured outside RUN, so it never coincides with a handshake.
         if (clear) begin
            sent_reg  <= 32'd0;
            cksum_reg <= 64'd0;
         end else if (hs) begin
            sent_reg  <= sent_reg + 32'(NB);
            cksum_reg <= cksum_step(cksum_reg, 64'(M_AXIS_TDATA));
         end
      end
   end

endmodule

// File: tb/tb_axis_dsrc.sv
// Scoreboard bench for axis_dsrc: stimulus pushes expected beats, a negedge monitor
// pops and compares them, and end-of-transfer checks compare counters with the model.
`timescale 1ns/1ps
module tb_axis_dsrc;
   localparam int NB  = 4;
   localparam int PKT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        tvalid;
   logic        tready;
   logic [31:0] tdata;
   logic [3:0]  tstrb;
   logic        tlast;
   logic [31:0] cmd;
   logic        new_cmd;
   logic [31:0] xfer_bytes;
   logic [31:0] seed;
   logic [31:0] stat;
   logic [31:0] sent_bytes;
   logic [63:0] checksum;

   always #5 clk = ~clk;

   axis_dsrc #(
      .C_M_AXIS_TDATA_NUM_BYTES (NB),
      .C_PKT_WORDS              (PKT)
   ) dut (
      .AXIS_ACLK     (clk),
      .AXIS_ARESET   (rst),
      .M_AXIS_TVALID (tvalid),
      .M_AXIS_TREADY (tready),
      .M_AXIS_TDATA  (tdata),
      .M_AXIS_TSTRB  (tstrb),
      .M_AXIS_TLAST  (tlast),
      .cmd           (cmd),
      .new_cmd       (new_cmd),
      .xfer_bytes    (xfer_bytes),
      .seed          (seed),
      .stat          (stat),
      .sent_bytes    (sent_bytes),
      .checksum      (checksum)
   );

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } beat_t;

   beat_t       exp_q[$];
   int          total = 0;
   int          bad   = 0;
   int          beat_no = 0;
   logic [31:0] mdl_sent = 32'd0;
   logic [63:0] mdl_ck   = 64'd0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compares every accepted beat against the scoreboard and checks stall stability.
   initial begin
      beat_t       e;
      logic        held = 1'b0;
      logic [31:0] held_data = 32'd0;
      logic        held_last = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            held = 1'b0;
         end else begin
            if (held) begin
               chk("stall_valid", 64'(tvalid), 64'd1);
               chk("stall_data", 64'(tdata), 64'(held_data));
               chk("stall_last", 64'(tlast), 64'(held_last));
            end
            if (tvalid) begin
               chk("strb", 64'(tstrb), 64'hF);
               if (tready) begin
                  held = 1'b0;
                  if (exp_q.size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL unexpected_beat: got data 0x%08h with empty scoreboard", tdata);
                  end else begin
                     e = exp_q.pop_front();
                     chk("beat_data", 64'(tdata), 64'(e.data));
                     chk("beat_last", 64'(tlast), 64'(e.last));
                     mdl_sent = mdl_sent + 32'(NB);
                     mdl_ck   = ((mdl_ck >> 1) | (mdl_ck << 63)) + 64'(e.data);
                     $display("beat %0d data=0x%08h last=%0d", beat_no, tdata, tlast);
                     beat_no++;
                  end
               end else begin
                  held      = 1'b1;
                  held_data = tdata;
                  held_last = tlast;
               end
            end else begin
               held = 1'b0;
            end
         end
      end
   end

   // Reference: n beats of seed+k; a packet closes every PKT beats or at the end of a finite transfer.
   task automatic start_xfer(input logic [31:0] xb, input logic [31:0] sd, input int cont_beats);
      int    n;
      beat_t b;
      n = (xb == 32'd0) ? cont_beats : int'((64'(xb) + 64'(NB - 1)) / 64'(NB));
      for (int k = 0; k < n; k++) begin
         b.data = sd + 32'(k);
         b.last = ((k % PKT) == PKT - 1) || ((xb != 32'd0) && (k == n - 1));
         exp_q.push_back(b);
      end
      $display("start xfer_bytes=%0d seed=0x%08h beats=%0d", xb, sd, n);
      chk("pre_start_valid", 64'(tvalid), 64'd0);
      cmd = 32'd1; xfer_bytes = xb; seed = sd; new_cmd = 1'b1;
      @(posedge clk); #2;
      new_cmd = 1'b0; cmd = 32'd0;
      chk("start_latency", 64'(tvalid), 64'd1);
   endtask

   task automatic run_until_done(input int mode, input int budget, output int cycles);
      int cyc = 0;
      while (exp_q.size() != 0 || tvalid) begin
         if (cyc == budget) begin
            total++;
            bad++;
            $display("FAIL timeout: %0d beats still pending after %0d cycles", exp_q.size(), cyc);
            exp_q.delete();
            cycles = cyc;
            return;
         end
         case (mode)
            0:       tready = 1'b1;
            1:       tready = ((cyc % 3) == 0);
            default: tready = 1'($urandom_range(0, 1));
         endcase
         @(posedge clk); #2;
         cyc++;
      end
      cycles = cyc;
   endtask

   task automatic clear_counters();
      $display("cmd reset");
      cmd = 32'd2; new_cmd = 1'b1;
      @(posedge clk); #2;
      new_cmd = 1'b0; cmd = 32'd0;
      chk("clr_sent", 64'(sent_bytes), 64'd0);
      chk("clr_ck", checksum, 64'd0);
      chk("clr_stat", 64'(stat), 64'd0);
      mdl_sent = 32'd0;
      mdl_ck   = 64'd0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          cyc;
      logic [63:0] ck_ref;
      logic [31:0] xb;
      rst = 1'b1; tready = 1'b0; new_cmd = 1'b0; cmd = 32'd0; xfer_bytes = 32'd0; seed = 32'd0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_valid", 64'(tvalid), 64'd0);
      chk("rst_data", 64'(tdata), 64'd0);
      chk("rst_last", 64'(tlast), 64'd0);
      chk("rst_stat", 64'(stat), 64'd0);
      chk("rst_sent", 64'(sent_bytes), 64'd0);
      chk("rst_ck", checksum, 64'd0);
      rst = 1'b0;
      @(posedge clk); #2;

      // 32 bytes at full throughput
      tready = 1'b1;
      start_xfer(32'd32, 32'h100, 0);
      run_until_done(0, 100, cyc);
      chk("t1_cycles", 64'(cyc), 64'd8);
      chk("t1_stat", 64'(stat), 64'h2);
      chk("t1_sent", 64'(sent_bytes), 64'd32);
      chk("t1_ck", checksum, mdl_ck);
      ck_ref = mdl_ck;

      // same transfer with 1,0,0 backpressure must give the same checksum
      clear_counters();
      start_xfer(32'd32, 32'h100, 0);
      run_until_done(1, 100, cyc);
      chk("t2_stat", 64'(stat), 64'h2);
      chk("t2_sent", 64'(sent_bytes), 64'd32);
      chk("t2_ck", checksum, ck_ref);

      // restart from DONE, non-multiple length, counters accumulate
      start_xfer(32'd10, 32'h2000, 0);
      run_until_done(0, 100, cyc);
      chk("t3_cycles", 64'(cyc), 64'd3);
      chk("t3_sent", 64'(sent_bytes), 64'd44);
      chk("t3_ck", checksum, mdl_ck);

      // shorter than one beat
      start_xfer(32'd3, 32'hABC, 0);
      run_until_done(0, 100, cyc);
      chk("t3b_cycles", 64'(cyc), 64'd1);
      chk("t3b_sent", 64'(sent_bytes), 64'd48);
      chk("t3b_stat", 64'(stat), 64'h2);

      // continuous with wrap, ignored commands in RUN, then stop while stalled
      clear_counters();
      tready = 1'b0;
      start_xfer(32'd0, 32'hFFFF_FFFE, 5);
      tready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 1) begin cmd = 32'd2; new_cmd = 1'b1; end
         if (i == 2) begin cmd = 32'd1; xfer_bytes = 32'd4; seed = 32'd0; new_cmd = 1'b1; end
         if (i == 3) begin cmd = 32'd7; new_cmd = 1'b1; end
         @(posedge clk); #2;
         new_cmd = 1'b0; cmd = 32'd0;
      end
      tready = 1'b0;
      cmd = 32'd3; new_cmd = 1'b1;
      $display("cmd stop");
      @(posedge clk); #2;
      new_cmd = 1'b0; cmd = 32'd0;
      chk("stop_pend_stat", 64'(stat), 64'h5);
      repeat (2) begin
         @(posedge clk); #2;
      end
      chk("stop_hold_valid", 64'(tvalid), 64'd1);
      tready = 1'b1;
      @(posedge clk); #2;
      tready = 1'b0;
      chk("stop_valid", 64'(tvalid), 64'd0);
      chk("stop_stat", 64'(stat), 64'h0);
      chk("stop_queue", 64'(exp_q.size()), 64'd0);
      chk("stop_sent", 64'(sent_bytes), 64'd20);
      chk("stop_ck", checksum, mdl_ck);

      // randomized lengths, seeds and backpressure
      for (int r = 0; r < 6; r++) begin
         xb = 32'($urandom_range(1, 40));
         start_xfer(xb, $urandom, 0);
         run_until_done(2, 400, cyc);
         chk("rnd_stat", 64'(stat), 64'h2);
         chk("rnd_sent", 64'(sent_bytes), 64'(mdl_sent));
         chk("rnd_ck", checksum, mdl_ck);
      end

      // asynchronous reset between clock edges
      tready = 1'b1;
      start_xfer(32'd64, 32'h200, 0);
      repeat (3) begin
         @(posedge clk); #2;
      end
      #1 rst = 1'b1;
      #1;
      $display("async reset asserted");
      chk("arst_valid", 64'(tvalid), 64'd0);
      chk("arst_data", 64'(tdata), 64'd0);
      chk("arst_last", 64'(tlast), 64'd0);
      chk("arst_strb", 64'(tstrb), 64'd0);
      chk("arst_stat", 64'(stat), 64'd0);
      chk("arst_sent", 64'(sent_bytes), 64'd0);
      chk("arst_ck", checksum, 64'd0);
      exp_q.delete();
      mdl_sent = 32'd0;
      mdl_ck   = 64'd0;
      @(posedge clk); #2;
      rst = 1'b0;
      @(posedge clk); #2;
      start_xfer(32'd8, 32'h55, 0);
      run_until_done(0, 100, cyc);
      chk("post_rst_sent", 64'(sent_bytes), 64'd8);
      chk("post_rst_ck", checksum, mdl_ck);
      chk("post_rst_stat", 64'(stat), 64'h2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axis_dsrc.md
Name: axis_dsrc

Overview:
- Simulation/bring-up AXI-Stream data source. It is the transmit-side counterpart of the team's AXI-Stream data sink.
- Generates a deterministic counting pattern of programmable length with periodic TLAST, under the same cmd/new_cmd/stat control scheme as the sink.
- Keeps a byte count and a rotate-add checksum with the same formula as the sink, so a source→DUT→sink chain can be checked end to end by comparing counters.

Parameters:
C_M_AXIS_TDATA_NUM_BYTES, 4, TDATA width in bytes (1..8).
C_PKT_WORDS, 16, beats per packet; TLAST on every C_PKT_WORDS-th beat (>=1).

Ports:
AXIS_ACLK  in  1  single clock for all logic.
AXIS_ARESET  in  1  asynchronous, active-high reset.
M_AXIS_TVALID  out  1  beat valid.
M_AXIS_TREADY  in  1  downstream ready.
M_AXIS_TDATA  out  8*NB  pattern data.
M_AXIS_TSTRB  out  NB  all ones whenever TVALID.
M_AXIS_TLAST  out  1  packet/transfer end marker.
cmd  in  32  command code (1 start, 2 reset, 3 stop); sampled only when new_cmd=1.
new_cmd  in  1  one-cycle command strobe.
xfer_bytes  in  32  transfer length, latched on start; 0 = continuous.
seed  in  32  first data word, latched on start.
stat  out  32  {29'h0, stop_pend, tx_done, tx_enable}.
sent_bytes  out  32  bytes accepted downstream.
checksum  out  64  running checksum of accepted beats.

Behaviour:
- Reset (AXIS_ARESET=1, async): state IDLE; TVALID/TLAST=0; TDATA=0; stat=0; sent_bytes=0; checksum=0; all counters 0.
- States: IDLE, RUN, DONE. stop_pend is a flag, not a state.
- IDLE + cmd 1:
  - Latch xfer_bytes and seed.
  - Beat target = ceil(xfer_bytes/NB).
  - Go to RUN. tx_enable=1.
  - TVALID rises on the cycle after the new_cmd edge (1-cycle latency).
- RUN:
  - TVALID stays high continuously. Full throughput: one beat per cycle while TREADY=1.
  - Handshake = TVALID & TREADY.
  - TDATA = seed + beat_idx, zero-extended to 8*NB; beat_idx counts from 0.
  - TDATA, TLAST and TSTRB are held stable while TVALID=1 and TREADY=0 (AXIS rule; never retract TVALID).
  - TLAST=1 when (pkt_cnt == C_PKT_WORDS-1) or (this is the final beat of a finite transfer).
  - pkt_cnt resets to 0 after every TLAST handshake.
- On each handshake:
  - sent_bytes += NB; wraps mod 2^32.
  - checksum <= {checksum[0], checksum[63:1]} + TDATA, zero-extended to 64 bits, mod 2^64.
  - beat_idx and pkt_cnt advance.
- Final-beat handshake (finite transfer): next state DONE; TVALID=0; tx_done=1; tx_enable=0.
- Continuous mode (xfer_bytes=0): never reaches DONE; beat_idx wraps freely.
- cmd 3 (stop):
  - In RUN: set stop_pend.
    - If TVALID=1 and TREADY=0, complete that beat first; after its handshake go to IDLE with TVALID=0.
    - Nominally TVALID is always 1 in RUN; the stop takes effect at the next handshake, including one in the same cycle as the command.
    - The stopped beat does not force TLAST.
  - Elsewhere: ignored. stop_pend clears on entry to IDLE.
- cmd 2 (reset):
  - In IDLE or DONE: next cycle sent_bytes=0, checksum=0, tx_done=0; state IDLE.
  - In RUN: ignored, to preserve the AXIS valid rule.
- cmd 1 in DONE: restart with a new latch.
  - Counters are not cleared; they accumulate, matching the sink.
- cmd 1 in RUN: ignored.
- Unknown cmd codes: ignored.
- xfer_bytes not a multiple of NB: round up; the last beat is full-width with TSTRB all ones.
- xfer_bytes < NB: one beat, TLAST=1.
- Reset asserted mid-beat: TVALID drops immediately, which is permitted under reset.

Decomposition:
- Shared package: command codes (CMD_START=1, CMD_RESET=2, CMD_STOP=3), the state enum, and a checksum-step function (rotate-right-1 then add).
  - The sink re-uses the same function so both ends stay bit-identical.
- One natural sub-module: axis_dsrc_ctrl (FSM plus beat/packet counters).
  - The datapath (TDATA, checksum, sent_bytes) stays in the top module.

Test Plan:
- NB=4, C_PKT_WORDS=4, seed=0x100, xfer_bytes=32, TREADY=1 → 8 beats 0x100..0x107 on consecutive cycles; TLAST on beats 3 and 7; sent_bytes=32; stat=0x2; checksum equals the reference-model value, and the sink's checksum matches it.
- Same as above with TREADY toggling 1,0,0,1... → TDATA/TLAST stable during stalls; identical final checksum; no beat dropped or duplicated.
- xfer_bytes=10, NB=4 → 3 beats, TLAST only on beat 2; sent_bytes=12.
- xfer_bytes=0, seed=0xFFFFFFFE; run 4 beats, then cmd 3 while TREADY=0 → TDATA 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 (wraps); pending beat completes when TREADY rises; then TVALID=0 and stat=0x0.
- cmd 2 during RUN → ignored, counters keep advancing. cmd 2 in DONE → sent_bytes=0, checksum=0, stat=0x0 on the next cycle.
- Assert AXIS_ARESET mid-transfer between clock edges → TVALID and all outputs go to 0 immediately; after release, cmd 1 starts cleanly from seed.
